// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle OTTER control unit.
package cu_pkg;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        FETCH     = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        INTERRUPT = 3'd5,
        TRAP      = 3'd6
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [2:0] CAUSE_FETCH = 3'd1;
    localparam logic [2:0] CAUSE_ILL   = 3'd2;
    localparam logic [2:0] CAUSE_LOAD  = 3'd5;
    localparam logic [2:0] CAUSE_STORE = 3'd7;

    // True for every opcode the core implements.
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS: is_legal = 1'b1;
            default:                                    is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cu_fsm_mc_if.sv
// Instruction/data memory handshake between the control unit and memory.
interface cu_fsm_mc_if;
    logic mem_ready1;
    logic mem_ready2;
    logic memRDEN1;
    logic memRDEN2;
    logic memWE2;

    modport master (input mem_ready1, mem_ready2, output memRDEN1, memRDEN2, memWE2);
    modport slave  (output mem_ready1, mem_ready2, input memRDEN1, memRDEN2, memWE2);
endinterface

// File: rtl/mem_wait_timer.sv
// Counts not-ready cycles of the active memory access and flags a timeout.
module mem_wait_timer #(
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ready,
    output logic timeout
);
    localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);
    // With the timeout disabled the counter saturates instead of wrapping.
    localparam logic [WAIT_W-1:0] SAT_C = (MAX_WAIT != 0) ? MAX_C : {WAIT_W{1'b1}};

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Next count: clear on state entry, else step while memory is not ready.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!ready && (cnt_q != SAT_C)) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign timeout = (MAX_WAIT != 0) && (cnt_q == MAX_C);
endmodule

// File: rtl/cu_fsm_mc.sv
// Multicycle OTTER control unit with memory wait states, interrupts and exceptions.
module cu_fsm_mc
    import cu_pkg::*;
#(
    parameter int unsigned NUM_IRQ  = 4,
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [6:0]         opcode,
    input  logic [2:0]         func3,
    input  logic [NUM_IRQ-1:0] intr_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               mie,
    cu_fsm_mc_if.master        mem,
    output logic               PCWrite,
    output logic               regWrite,
    output logic               reset,
    output logic               mret_exec,
    output logic               int_taken,
    output logic               csr_WE,
    output logic [3:0]         trap_cause
);
    state_t       ps_q, ps_d;
    logic         is_load_q, is_load_d;
    logic [3:0]   trap_cause_q, trap_cause_d;
    logic         rden1_c, rden2_c, we2_c;
    logic         timeout, tmr_clr, tmr_ready;
    logic [NUM_IRQ-1:0] act;
    logic [2:0]   irq_idx;
    logic         pend;
    state_t       end_state;

    // Lowest-numbered enabled request wins; no request yields index 0.
    always_comb begin
        act     = intr_req & irq_en;
        pend    = mie & (|act);
        irq_idx = 3'd0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (act[i]) irq_idx = 3'(i);
        end
        end_state = pend ? INTERRUPT : FETCH;
    end

    // Next state, strobes and cause selection.
    always_comb begin
        ps_d         = ps_q;
        is_load_d    = is_load_q;
        trap_cause_d = trap_cause_q;
        PCWrite      = 1'b0;
        regWrite     = 1'b0;
        reset        = 1'b0;
        mret_exec    = 1'b0;
        int_taken    = 1'b0;
        csr_WE       = 1'b0;
        rden1_c      = 1'b0;
        rden2_c      = 1'b0;
        we2_c        = 1'b0;
        case (ps_q)
            INIT: begin
                reset = 1'b1;
                ps_d  = FETCH;
            end
            FETCH: begin
                rden1_c = 1'b1;
                if (mem.mem_ready1) begin
                    ps_d = EXECUTE;
                end else if (timeout) begin
                    ps_d         = TRAP;
                    trap_cause_d = {1'b0, CAUSE_FETCH};
                end
            end
            EXECUTE: begin
                if (!is_legal(opcode)) begin
                    ps_d         = TRAP;
                    trap_cause_d = {1'b0, CAUSE_ILL};
                end else begin
                    case (opcode)
                        OP_LOAD: begin
                            rden2_c   = 1'b1;
                            is_load_d = 1'b1;
                            ps_d      = MEM;
                        end
                        OP_STORE: begin
                            we2_c     = 1'b1;
                            is_load_d = 1'b0;
                            ps_d      = MEM;
                        end
                        OP_BRANCH: begin
                            PCWrite = 1'b1;
                            ps_d    = end_state;
                        end
                        OP_SYS: begin
                            PCWrite = 1'b1;
                            if (func3 == 3'b000) begin
                                mret_exec = 1'b1;
                            end else begin
                                regWrite = 1'b1;
                                csr_WE   = 1'b1;
                            end
                            ps_d = end_state;
                        end
                        default: begin
                            PCWrite  = 1'b1;
                            regWrite = 1'b1;
                            ps_d     = end_state;
                        end
                    endcase
                end
            end
            MEM: begin
                rden2_c = is_load_q;
                we2_c   = !is_load_q;
                if (mem.mem_ready2) begin
                    if (is_load_q) begin
                        ps_d = WRITEBACK;
                    end else begin
                        PCWrite = 1'b1;
                        ps_d    = end_state;
                    end
                end else if (timeout) begin
                    ps_d         = TRAP;
                    trap_cause_d = {1'b0, is_load_q ? CAUSE_LOAD : CAUSE_STORE};
                end
            end
            WRITEBACK: begin
                PCWrite  = 1'b1;
                regWrite = 1'b1;
                ps_d     = end_state;
            end
            INTERRUPT: begin
                PCWrite      = 1'b1;
                int_taken    = 1'b1;
                trap_cause_d = {1'b1, irq_idx};
                ps_d         = FETCH;
            end
            TRAP: begin
                PCWrite   = 1'b1;
                int_taken = 1'b1;
                ps_d      = FETCH;
            end
            default: ps_d = INIT;
        endcase
    end

    // State, load flag and cause registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ps_q         <= INIT;
            is_load_q    <= 1'b0;
            trap_cause_q <= 4'd0;
        end else begin
            ps_q         <= ps_d;
            is_load_q    <= is_load_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign tmr_ready = (ps_q == MEM) ? mem.mem_ready2 : mem.mem_ready1;
    assign tmr_clr   = ((ps_d == FETCH) && (ps_q != FETCH)) ||
                       ((ps_d == MEM)   && (ps_q != MEM));

    mem_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk     (clk),
        .rst     (RST),
        .clr     (tmr_clr),
        .ready   (tmr_ready),
        .timeout (timeout)
    );

    assign mem.memRDEN1 = rden1_c;
    assign mem.memRDEN2 = rden2_c;
    assign mem.memWE2   = we2_c;
    assign trap_cause   = trap_cause_q;
endmodule

// File: tb/tb_cu_fsm_mc.sv
// Directed bench for cu_fsm_mc: default-timeout instance A, short-timeout instance B.
module tb_cu_fsm_mc;
    import cu_pkg::*;

    logic       clk;
    logic       RST;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [3:0] intr_req;
    logic [3:0] irq_en;
    logic       mie;

    logic       a_pcw, a_rw, a_rst, a_mret, a_taken, a_csr;
    logic [3:0] a_cause;
    logic       b_pcw, b_rw, b_rst, b_mret, b_taken, b_csr;
    logic [3:0] b_cause;

    int vectors;
    int miscompares;

    cu_fsm_mc_if bus_a ();
    cu_fsm_mc_if bus_b ();

    cu_fsm_mc #(.NUM_IRQ(4), .WAIT_W(4), .MAX_WAIT(15)) dut_a (
        .clk(clk), .RST(RST), .opcode(opcode), .func3(func3),
        .intr_req(intr_req), .irq_en(irq_en), .mie(mie), .mem(bus_a.master),
        .PCWrite(a_pcw), .regWrite(a_rw), .reset(a_rst), .mret_exec(a_mret),
        .int_taken(a_taken), .csr_WE(a_csr), .trap_cause(a_cause)
    );

    cu_fsm_mc #(.NUM_IRQ(4), .WAIT_W(4), .MAX_WAIT(2)) dut_b (
        .clk(clk), .RST(RST), .opcode(opcode), .func3(func3),
        .intr_req(intr_req), .irq_en(irq_en), .mie(mie), .mem(bus_b.master),
        .PCWrite(b_pcw), .regWrite(b_rw), .reset(b_rst), .mret_exec(b_mret),
        .int_taken(b_taken), .csr_WE(b_csr), .trap_cause(b_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b1;
        opcode      = OP_RTYPE;
        func3       = 3'b000;
        intr_req    = 4'b0000;
        irq_en      = 4'b1111;
        mie         = 1'b0;
        bus_a.mem_ready1 = 1'b1;
        bus_a.mem_ready2 = 1'b1;
        bus_b.mem_ready1 = 1'b0;
        bus_b.mem_ready2 = 1'b0;

        #12;
        chk("rst_reset_a", 32'(a_rst), 32'd1);
        chk("rst_pcw_a", 32'(a_pcw), 32'd0);
        chk("rst_cause_a", 32'(a_cause), 32'd0);
        chk("rst_cause_b", 32'(b_cause), 32'd0);
        RST = 1'b0;

        // ADD finishing with a pending interrupt; B stalls its fetch meanwhile
        tick();
        chk("fetch_rden1_a", 32'(bus_a.memRDEN1), 32'd1);
        chk("fetch_reset_a", 32'(a_rst), 32'd0);
        intr_req = 4'b1010;
        mie      = 1'b1;
        tick();
        chk("add_pcw", 32'(a_pcw), 32'd1);
        chk("add_rw", 32'(a_rw), 32'd1);
        chk("add_we2", 32'(bus_a.memWE2), 32'd0);
        chk("b_fetch2_taken", 32'(b_taken), 32'd0);
        tick();
        chk("irq_taken", 32'(a_taken), 32'd1);
        chk("irq_pcw", 32'(a_pcw), 32'd1);
        chk("b_fetch3_rden1", 32'(bus_b.memRDEN1), 32'd1);
        chk("b_fetch3_taken", 32'(b_taken), 32'd0);
        mie = 1'b0;
        tick();
        chk("irq_cause", 32'(a_cause), 32'h9);
        chk("b_trap_taken", 32'(b_taken), 32'd1);
        chk("b_trap_pcw", 32'(b_pcw), 32'd1);
        chk("b_trap_cause", 32'(b_cause), 32'h1);
        tick();
        chk("add_nomie_pcw", 32'(a_pcw), 32'd1);
        tick();
        chk("nomie_state", 32'(dut_a.ps_q), 32'(FETCH));
        chk("nomie_taken", 32'(a_taken), 32'd0);
        chk("cause_hold", 32'(a_cause), 32'h9);

        // Load with three not-ready data cycles: 1+1+4+1 cycles
        intr_req         = 4'b0000;
        opcode           = OP_LOAD;
        bus_a.mem_ready2 = 1'b0;
        chk("ld_fetch_rden1", 32'(bus_a.memRDEN1), 32'd1);
        tick();
        chk("ld_exec_rden2", 32'(bus_a.memRDEN2), 32'd1);
        chk("ld_exec_pcw", 32'(a_pcw), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) bus_a.mem_ready2 = 1'b1;
            #1;
            chk("ld_mem_rden2", 32'(bus_a.memRDEN2), 32'd1);
            chk("ld_mem_pcw", 32'(a_pcw), 32'd0);
            chk("ld_mem_rw", 32'(a_rw), 32'd0);
        end
        tick();
        chk("ld_wb_pcw", 32'(a_pcw), 32'd1);
        chk("ld_wb_rw", 32'(a_rw), 32'd1);
        chk("ld_wb_rden2", 32'(bus_a.memRDEN2), 32'd0);
        tick();
        chk("ld_end_rden1", 32'(bus_a.memRDEN1), 32'd1);
        chk("ld_end_pcw", 32'(a_pcw), 32'd0);
        chk("ld_end_rw", 32'(a_rw), 32'd0);

        // Illegal opcode traps without strobes
        opcode = 7'b0001011;
        tick();
        chk("ill_exec_rw", 32'(a_rw), 32'd0);
        chk("ill_exec_we2", 32'(bus_a.memWE2), 32'd0);
        chk("ill_exec_pcw", 32'(a_pcw), 32'd0);
        tick();
        chk("ill_trap_taken", 32'(a_taken), 32'd1);
        chk("ill_trap_pcw", 32'(a_pcw), 32'd1);
        chk("ill_trap_rw", 32'(a_rw), 32'd0);
        chk("ill_cause", 32'(a_cause), 32'h2);
        tick();

        // Branch, mret and CSR system instructions
        opcode = OP_BRANCH;
        tick();
        chk("br_pcw", 32'(a_pcw), 32'd1);
        chk("br_rw", 32'(a_rw), 32'd0);
        tick();
        opcode = OP_SYS;
        func3  = 3'b000;
        tick();
        chk("mret_exec", 32'(a_mret), 32'd1);
        chk("mret_csr", 32'(a_csr), 32'd0);
        tick();
        func3 = 3'b001;
        tick();
        chk("csr_we", 32'(a_csr), 32'd1);
        chk("csr_rw", 32'(a_rw), 32'd1);
        chk("csr_mret", 32'(a_mret), 32'd0);
        tick();

        // Store timeout while an interrupt is pending: exception wins
        opcode           = OP_STORE;
        func3            = 3'b010;
        bus_a.mem_ready2 = 1'b0;
        intr_req         = 4'b0001;
        mie              = 1'b1;
        tick();
        chk("st_exec_we2", 32'(bus_a.memWE2), 32'd1);
        chk("st_exec_pcw", 32'(a_pcw), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("st_mem_we2", 32'(bus_a.memWE2), 32'd1);
            chk("st_mem_pcw", 32'(a_pcw), 32'd0);
        end
        tick();
        chk("st_trap_taken", 32'(a_taken), 32'd1);
        chk("st_trap_cause", 32'(a_cause), 32'h7);
        tick();
        chk("st_after_state", 32'(dut_a.ps_q), 32'(FETCH));
        chk("st_after_taken", 32'(a_taken), 32'd0);

        // Reset pulse while a store is waiting in MEM
        intr_req = 4'b0000;
        mie      = 1'b0;
        tick();
        tick();
        chk("rstmem_we2_pre", 32'(bus_a.memWE2), 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("rstmem_we2", 32'(bus_a.memWE2), 32'd0);
        chk("rstmem_reset", 32'(a_rst), 32'd1);
        chk("rstmem_cause", 32'(a_cause), 32'd0);
        #1 RST = 1'b0;
        tick();
        chk("rstmem_state", 32'(dut_a.ps_q), 32'(FETCH));
        chk("rstmem_rden1", 32'(bus_a.memRDEN1), 32'd1);
        chk("rstmem_cause2", 32'(a_cause), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
